// File: rtl/dfe_apb_cfg_regfile_if.sv
// APB completer bus bundle for the DFE configuration register bank.
// The master modport is the bridge side; the slave modport is the register bank.
interface dfe_apb_cfg_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/dfe_apb_cfg_regfile.sv
// APB register bank driving DFE filter coefficients/control, with programmable wait
// states and decode-error reporting. Register 0 is a read-only view of status_in.
//
//   state  | meaning
//   IDLE   | no transfer in flight; waiting for a setup phase
//   ACCESS | transfer selected; counting wait states, then completing
module dfe_apb_cfg_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    localparam int                   IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    dfe_apb_cfg_regfile_if.slave           apb,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
    output logic                           cfg_wr_pulse,
    output logic [IDX_W-1:0]               cfg_wr_idx
);

    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_q;
    logic [3:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_pulse_q;
    logic [IDX_W-1:0]      wr_idx_q;

    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic                  err;
    logic                  pready;
    logic                  commit;

    // Borrow out of the extended subtraction flags addresses below the bank.
    always_comb begin
        diff   = {1'b0, apb.PADDR} - {1'b0, BASE_ADDR};
        off    = diff[ADDR_WIDTH-1:0];
        idx    = off[2 +: IDX_W];
        err    = diff[ADDR_WIDTH] || (off >= SPAN) || (apb.PADDR[1:0] != 2'b00)
                 || (apb.PWRITE && (idx == '0));
        pready = (state_q == ACCESS) && apb.PSEL && (wait_cnt_q == 4'd0);
        commit = apb.PSEL && apb.PENABLE && pready && apb.PWRITE && !err;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse_q <= commit;
            if (commit) begin
                regs_q[idx] <= apb.PWDATA;
                wr_idx_q    <= idx;
            end
            case (state_q)
                IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        state_q    <= ACCESS;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                ACCESS: begin
                    if (!apb.PSEL) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q != 4'd0) begin
                        if (apb.PENABLE) wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else if (!apb.PENABLE) begin
                        wait_cnt_q <= WAIT_INIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_regs = '0;
        for (int i = 1; i < NUM_REGS; i++) cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = err && pready;
    assign apb.PRDATA  = (pready && !err) ? ((idx == '0) ? status_in : regs_q[idx]) : '0;
    assign cfg_wr_pulse = wr_pulse_q;
    assign cfg_wr_idx   = wr_idx_q;

endmodule

// File: tb/tb_dfe_apb_cfg_regfile.sv
// Self-checking bench for dfe_apb_cfg_regfile: directed vector table, hand-written
// back-to-back and reset-abort sequences, then random transfers against an address-map model.
module tb_dfe_apb_cfg_regfile;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NR   = 16;
    localparam int          WS   = 1;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic [DW-1:0]    status_in = '0;
    logic [NR*DW-1:0] cfg_regs;
    logic             cfg_wr_pulse;
    logic [3:0]       cfg_wr_idx;

    dfe_apb_cfg_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dfe_apb_cfg_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(WS), .BASE_ADDR(BASE)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus), .status_in(status_in),
        .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .cfg_wr_idx(cfg_wr_idx)
    );

    always #5 PCLK = ~PCLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_regs [NR];
    bit          pend = 0;
    logic [3:0]  pend_idx = '0;
    bit          pulse_exp = 0;
    logic [3:0]  idx_exp = '0;
    bit          mon_en = 0;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] status;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        logic [NR*DW-1:0] exp;
        exp = '0;
        for (int i = 1; i < NR; i++) exp[i*DW +: DW] = mdl_regs[i];
        checks++;
        if (cfg_regs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, cfg_regs, exp);
        end
    endtask

    function automatic bit mdl_err(input bit w, input logic [31:0] a);
        if (a < BASE) return 1'b1;
        if ((a - BASE) >= NR * 4) return 1'b1;
        if ((a % 4) != 0) return 1'b1;
        if (w && ((a - BASE) / 4 == 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        int k;
        if (mdl_err(1'b0, a)) return 32'h0;
        k = int'((a - BASE) / 4);
        return (k == 0) ? status_in : mdl_regs[k];
    endfunction

    // Expected write pulse/index follow a model commit by one clock.
    always @(posedge PCLK) begin
        pulse_exp = pend;
        if (pend) idx_exp = pend_idx;
        pend = 1'b0;
    end

    always @(negedge PCLK) begin
        if (mon_en) begin
            chk("wr_pulse", cfg_wr_pulse, pulse_exp);
            chk("wr_idx", cfg_wr_idx, idx_exp);
        end
    end

    task automatic idle();
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic slverr, output int waits);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge PCLK);
            if (bus.PREADY) break;
            if (!w) chk("wait_prdata", bus.PRDATA, 32'h0);
            chk("wait_pslverr", 32'(bus.PSLVERR), 32'h0);
            waits++;
            if (waits > 20) begin
                checks++; errors++;
                $display("FAIL pready_timeout: got no PREADY after %0d cycles, expected %0d", waits, WS);
                break;
            end
            @(posedge PCLK); #1;
        end
        rd = bus.PRDATA;
        slverr = bus.PSLVERR;
    endtask

    task automatic model_commit(input bit w, input bit e, input logic [31:0] a, input logic [31:0] wd);
        int k;
        if (w && !e) begin
            k = int'((a - BASE) / 4);
            mdl_regs[k] = wd;
            pend = 1'b1;
            pend_idx = 4'(k);
        end
    endtask

    task automatic run(input bit w, input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit          e;
        logic [31:0] er, rd;
        logic        se;
        int          waits;
        e  = mdl_err(w, a);
        er = mdl_rd(a);
        xfer(w, a, wd, rd, se, waits);
        chk({tag, "_waits"}, 32'(waits), 32'(WS));
        chk({tag, "_pslverr"}, 32'(se), 32'(e));
        if (!w) chk({tag, "_prdata"}, rd, er);
        model_commit(w, e, a, wd);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd;
        logic        se;
        int          waits;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;

        tbl.push_back('{1'b1, BASE + 32'h08, 32'hA5A5_0001, 32'h0,  1'b0, 32'h0});
        tbl.push_back('{1'b0, BASE + 32'h08, 32'h0,        32'h0,  1'b0, 32'hA5A5_0001});
        tbl.push_back('{1'b0, BASE + 32'h00, 32'h0,        32'hFF, 1'b0, 32'h0000_00FF});
        tbl.push_back('{1'b1, BASE + 32'h00, 32'h1234,     32'hFF, 1'b1, 32'h0});
        tbl.push_back('{1'b1, BASE + 32'h40, 32'h7777,     32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b1, BASE + 32'h06, 32'h6666,     32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b0, BASE + 32'h40, 32'h0,        32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b0, BASE - 32'h04, 32'h0,        32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b1, BASE + 32'h3C, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b0, BASE + 32'h3C, 32'h0,        32'h0,  1'b0, 32'hDEAD_BEEF});
        tbl.push_back('{1'b0, BASE + 32'h3E, 32'h0,        32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b0, 32'h0000_0008, 32'h0,        32'h0,  1'b1, 32'h0});
        tbl.push_back('{1'b0, BASE + 32'h08, 32'h0,        32'h0,  1'b0, 32'hA5A5_0001});

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", 32'(bus.PREADY), 32'h0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_wr_pulse", 32'(cfg_wr_pulse), 32'h0);
        chk("rst_wr_idx", 32'(cfg_wr_idx), 32'h0);
        chk_regs("rst_cfg_regs");
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            status_in = tbl[i].status;
            xfer(tbl[i].w, tbl[i].addr, tbl[i].wdata, rd, se, waits);
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(WS));
            chk($sformatf("vec%0d_pslverr", i), 32'(se), 32'(tbl[i].exp_err));
            if (!tbl[i].w) chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
            model_commit(tbl[i].w, tbl[i].exp_err, tbl[i].addr, tbl[i].wdata);
            if (i % 2 == 1) idle();
        end
        idle();
        chk_regs("vec_cfg_regs");

        run(1'b1, BASE + 32'h0C, 32'hCAFE_0003, "b2b_wr");
        run(1'b0, BASE + 32'h0C, 32'h0, "b2b_rd");
        run(1'b1, BASE + 32'h14, 32'h5555_0005, "pre_rst_wr");
        idle();
        idle();

        // Reset lands in the wait cycle of a write to register 5.
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = BASE + 32'h14; bus.PWDATA = 32'h9999_0005;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rstmid_wait_pready", 32'(bus.PREADY), 32'h0);
        #1;
        PRESETn = 1'b0;
        idx_exp = '0;
        for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
        #1;
        chk("rstmid_pready", 32'(bus.PREADY), 32'h0);
        chk_regs("rstmid_cfg_regs");
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_pready", 32'(bus.PREADY), 32'h0);
        run(1'b0, BASE + 32'h14, 32'h0, "post_rst_rd5");
        idle();

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, NR - 1));
            else if (r == 7) a = BASE + 32'($urandom_range(0, NR * 4 - 1));
            else if (r == 8) a = BASE + 32'(NR * 4) + 32'(4 * $urandom_range(0, NR - 1));
            else             a = BASE - 32'(4 * $urandom_range(1, 8));
            status_in = $urandom();
            run(1'($urandom_range(0, 1)), a, $urandom(), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk_regs("final_cfg_regs");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
